// File: rtl/ifetch_sram_if.sv
// ifetch_sram_if
//   Instruction-side bus master placed directly after ifetch. Each accepted
//   fetch PC becomes one SRAM-like read on the instruction bus. The returned
//   word is buffered and presented to decode as {pc, inst, adel} with a
//   valid/ready handshake. At most one bus request is outstanding. A flush
//   kills the buffered or in-flight fetch; a response that belongs to a
//   killed fetch is dropped when it arrives.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   pc_i, pc_valid_i      fetch request from ifetch
//   flush_i               redirect; pc_i carries the new target
//   inst_req, inst_addr   bus read request and word address
//   inst_addr_ok          address accepted by the bus
//   inst_data_ok          read data returned (inst_rdata)
//   inst_valid_o          presented instruction valid for decode
//   id_ready_i            decode consumes the presented instruction
//   inst_pc_o, inst_o     PC and word of the presented instruction
//   adel_o                misaligned PC; no bus access was made
//   fetch_stall_o         ifetch must hold its PC
module ifetch_sram_if #(
    parameter int KSEG_MAP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    input  logic        pc_valid_i,
    input  logic        flush_i,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        inst_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] inst_pc_o,
    output logic [31:0] inst_o,
    output logic        adel_o,
    output logic        fetch_stall_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FULL
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_r, pc_n;
    logic [31:0] addr_r, addr_n;
    logic [31:0] inst_r, inst_n;
    logic        adel_r, adel_n;
    logic        cancel, cancel_n;
    logic        pend_valid, pend_valid_n;
    logic [31:0] pend_pc, pend_pc_n;
    logic        launch;
    logic [31:0] launch_pc;

    // kseg0/kseg1 fold onto physical address 0; low two bits always cleared
    function automatic logic [31:0] map_addr(input logic [31:0] p);
        if ((KSEG_MAP != 0) && ((p[31:29] == 3'b100) || (p[31:29] == 3'b101)))
            return {3'b000, p[28:2], 2'b00};
        else
            return {p[31:2], 2'b00};
    endfunction

    assign inst_req      = (state == REQ);
    assign inst_addr     = addr_r;
    assign inst_valid_o  = (state == FULL);
    assign inst_pc_o     = pc_r;
    assign inst_o        = inst_r;
    assign adel_o        = adel_r;
    assign fetch_stall_o = ((state != IDLE) && !((state == FULL) && id_ready_i))
                           || cancel || pend_valid;

    always_comb begin
        state_n      = state;
        pc_n         = pc_r;
        addr_n       = addr_r;
        inst_n       = inst_r;
        adel_n       = adel_r;
        cancel_n     = cancel;
        pend_valid_n = pend_valid;
        pend_pc_n    = pend_pc;
        launch       = 1'b0;
        launch_pc    = pc_i;

        case (state)
            IDLE: begin
                if (pc_valid_i)
                    launch = 1'b1;
            end
            FULL: begin
                if (flush_i || id_ready_i) begin
                    state_n = IDLE;
                    if (pc_valid_i)
                        launch = 1'b1;
                end
            end
            REQ: begin
                // request cannot be withdrawn: keep driving the old address
                if (flush_i) begin
                    cancel_n = 1'b1;
                    if (pc_valid_i) begin
                        pend_valid_n = 1'b1;
                        pend_pc_n    = pc_i;
                    end
                end
                if (inst_addr_ok)
                    state_n = WAIT;
            end
            WAIT: begin
                if (inst_data_ok) begin
                    if (cancel || flush_i) begin
                        // killed response: drop it and start the redirect target;
                        // a flush in this very cycle supersedes any stored target
                        cancel_n     = 1'b0;
                        pend_valid_n = 1'b0;
                        state_n      = IDLE;
                        if (flush_i && pc_valid_i) begin
                            launch = 1'b1;
                        end else if (pend_valid) begin
                            launch    = 1'b1;
                            launch_pc = pend_pc;
                        end
                    end else begin
                        inst_n  = inst_rdata;
                        adel_n  = 1'b0;
                        state_n = FULL;
                    end
                end else if (flush_i) begin
                    cancel_n = 1'b1;
                    if (pc_valid_i) begin
                        pend_valid_n = 1'b1;
                        pend_pc_n    = pc_i;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (launch) begin
            pc_n = launch_pc;
            if (launch_pc[1:0] != 2'b00) begin
                adel_n  = 1'b1;
                inst_n  = '0;
                state_n = FULL;
            end else begin
                adel_n  = 1'b0;
                addr_n  = map_addr(launch_pc);
                state_n = REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc_r       <= '0;
            addr_r     <= '0;
            inst_r     <= '0;
            adel_r     <= 1'b0;
            cancel     <= 1'b0;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else begin
            state      <= state_n;
            pc_r       <= pc_n;
            addr_r     <= addr_n;
            inst_r     <= inst_n;
            adel_r     <= adel_n;
            cancel     <= cancel_n;
            pend_valid <= pend_valid_n;
            pend_pc    <= pend_pc_n;
        end
    end

endmodule

// File: tb/tb_ifetch_sram_if.sv
module tb_ifetch_sram_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        flush_i;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        inst_valid_o;
    logic        id_ready_i;
    logic [31:0] inst_pc_o;
    logic [31:0] inst_o;
    logic        adel_o;
    logic        fetch_stall_o;

    int checks = 0;
    int errors = 0;

    ifetch_sram_if #(.KSEG_MAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .pc_valid_i(pc_valid_i),
        .flush_i(flush_i), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .inst_valid_o(inst_valid_o),
        .id_ready_i(id_ready_i), .inst_pc_o(inst_pc_o), .inst_o(inst_o),
        .adel_o(adel_o), .fetch_stall_o(fetch_stall_o)
    );

    always #5 clk = ~clk;

    // Transaction-level reference: one fetch in flight on the bus (request
    // phase or response phase), an output buffer, a "discard" mark on the
    // in-flight fetch and one queued redirect target.
    logic        m_out_v, m_out_adel, m_req, m_resp, m_drop, m_q_v;
    logic [31:0] m_out_pc, m_out_inst, m_addr, m_q_pc, m_cur_pc;

    function automatic logic [31:0] phys(input logic [31:0] p);
        logic [31:0] a;
        a = p;
        if (p[31:30] == 2'b10) a[31:29] = 3'b000;
        a[1:0] = 2'b00;
        return a;
    endfunction

    // memory contents seen by the bus
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic m_reset();
        m_out_v = 0; m_out_adel = 0; m_req = 0; m_resp = 0; m_drop = 0; m_q_v = 0;
        m_out_pc = 0; m_out_inst = 0; m_addr = 0; m_q_pc = 0; m_cur_pc = 0;
    endtask

    task automatic m_start(input logic [31:0] p);
        m_cur_pc = p;
        if (p[1:0] != 2'b00) begin
            m_out_v = 1; m_out_pc = p; m_out_adel = 1; m_out_inst = 0;
        end else begin
            m_req = 1; m_addr = phys(p);
        end
    endtask

    task automatic m_step(input logic pv, input logic [31:0] pc, input logic fl,
                          input logic aok, input logic dok, input logic rdy);
        if (m_req) begin
            if (fl) begin
                m_drop = 1;
                if (pv) begin m_q_v = 1; m_q_pc = pc; end
            end
            if (aok) begin m_req = 0; m_resp = 1; end
        end else if (m_resp) begin
            if (dok) begin
                m_resp = 0;
                if (m_drop || fl) begin
                    m_drop = 0;
                    if (fl && pv) m_start(pc);
                    else if (m_q_v) m_start(m_q_pc);
                    m_q_v = 0;
                end else begin
                    m_out_v = 1; m_out_pc = m_cur_pc; m_out_adel = 0;
                    m_out_inst = mem(m_addr);
                end
            end else if (fl) begin
                m_drop = 1;
                if (pv) begin m_q_v = 1; m_q_pc = pc; end
            end
        end else if (fl) begin
            m_out_v = 0;
            if (pv) m_start(pc);
        end else if (m_out_v) begin
            if (rdy) begin
                m_out_v = 0;
                if (pv) m_start(pc);
            end
        end else if (pv) begin
            m_start(pc);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic stall;
        stall = m_req || m_resp || m_drop || m_q_v || (m_out_v && !id_ready_i);
        chk("inst_req", {31'd0, inst_req}, {31'd0, m_req});
        if (m_req) chk("inst_addr", inst_addr, m_addr);
        chk("inst_valid_o", {31'd0, inst_valid_o}, {31'd0, m_out_v});
        if (m_out_v) begin
            chk("inst_pc_o", inst_pc_o, m_out_pc);
            chk("inst_o", inst_o, m_out_inst);
            chk("adel_o", {31'd0, adel_o}, {31'd0, m_out_adel});
        end
        chk("fetch_stall_o", {31'd0, fetch_stall_o}, {31'd0, stall});
    endtask

    // one clock: drive inputs after the falling edge, compare, advance model
    task automatic cyc(input logic pv, input logic [31:0] pc, input logic fl,
                       input logic aok, input logic dok, input logic rdy);
        @(negedge clk);
        pc_valid_i   = pv;
        pc_i         = pc;
        flush_i      = fl;
        inst_addr_ok = aok;
        inst_data_ok = dok;
        inst_rdata   = dok ? mem(m_addr) : $urandom;
        id_ready_i   = rdy;
        #1;
        check_all();
        m_step(pv, pc, fl, aok, dok, rdy);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = $urandom;
        if ($urandom_range(0, 7) != 0) p[1:0] = 2'b00;
        else p[1:0] = 2'($urandom_range(1, 3));
        return p;
    endfunction

    initial begin
        logic pv, fl, aok, dok, rdy;
        logic [31:0] pc;

        rst_n = 0; pc_i = 0; pc_valid_i = 0; flush_i = 0; inst_addr_ok = 0;
        inst_data_ok = 0; inst_rdata = 0; id_ready_i = 0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst inst_req", {31'd0, inst_req}, 32'd0);
        chk("rst inst_addr", inst_addr, 32'd0);
        chk("rst inst_valid_o", {31'd0, inst_valid_o}, 32'd0);
        chk("rst inst_pc_o", inst_pc_o, 32'd0);
        chk("rst inst_o", inst_o, 32'd0);
        chk("rst fetch_stall_o", {31'd0, fetch_stall_o}, 32'd0);
        rst_n = 1;

        // 1: kseg1 fetch, addr_ok at once, data_ok next -> valid 3 cycles later
        cyc(1, 32'hBFC0_0000, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t1 inst_addr", inst_addr, 32'h1FC0_0000);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t1 valid", {31'd0, inst_valid_o}, 32'd1);
        chk("t1 inst_o", inst_o, mem(32'h1FC0_0000));
        chk("t1 inst_pc_o", inst_pc_o, 32'hBFC0_0000);

        // 2: addr_ok delayed four cycles
        cyc(1, 32'h0040_0010, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk("t2 req held", {inst_req, fetch_stall_o, inst_addr[29:0]}, {2'b11, 30'h0040_0010});
        end
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);

        // 3: decode stalls three cycles, then consumes with the next PC ready
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h0040_0014, 0, 0, 0, 0);
            chk("t3 held", inst_pc_o, 32'h0040_0010);
        end
        cyc(1, 32'h0040_0014, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t3 next req", {31'd0, inst_req}, 32'd1);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);

        // 4: flush in WAIT redirects to kseg0 target
        cyc(1, 32'h0000_2000, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 32'h8000_1000, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("t4 dropped", {31'd0, inst_valid_o}, 32'd0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t4 addr", inst_addr, 32'h0000_1000);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t4 pc", inst_pc_o, 32'h8000_1000);

        // 5: misaligned PC
        cyc(1, 32'hBFC0_0002, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t5 adel", {inst_req, inst_valid_o, adel_o}, 32'd3);
        chk("t5 inst_o", inst_o, 32'd0);

        // 6: asynchronous reset during WAIT, then a stale data_ok is ignored
        cyc(1, 32'h0000_3000, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        inst_addr_ok = 0;
        #2 rst_n = 0;
        #1;
        chk("t6 rst outs", {inst_req, inst_valid_o, adel_o, fetch_stall_o}, 32'd0);
        chk("t6 rst addr", inst_addr, 32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1;
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            fl  = ($urandom_range(0, 9) == 0);
            pv  = fl || ($urandom_range(0, 9) < 6);
            pc  = rand_pc();
            rdy = ($urandom_range(0, 9) < 7);
            aok = m_req && $urandom_range(0, 1) == 1;
            dok = m_resp && $urandom_range(0, 1) == 1;
            cyc(pv, pc, fl, aok, dok, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
